servant_spi_sram_slave: RTL and testbench
=========================================

// Module: servant_spi_sram_slave
// PURPOSE
//  Serial SRAM device (23LC-style) for the servant SPI memory path: SPI mode-0 slave that
//  decodes READ/WRITE/RDMR/WRMR and stores bytes in a parametrised internal array. Runs
//  entirely on i_clk: SCK/CS_N/MOSI are synchronised and edge-detected, no SCK clock domain.
//  Supersedes the bare byte RAM: adds command FSM, addressing modes, page wrap and tri-state MISO.
// PARAMETERS
//  depth       65536  bytes of storage; power of two
//  aw          $clog2(depth)  internal address width
//  ADDR_BYTES  2      address bytes after opcode (2 or 3); bits above aw ignored
//  PAGE_SIZE   32     page length in bytes for page mode; power of two, <= depth
//  memfile     ""     optional $readmemh preload, one byte per line
// PORTS
//  i_clk      in   1  system clock
//  i_rst_n    in   1  asynchronous active-low reset
//  i_sck      in   1  SPI clock from master, async to i_clk, CPOL=0/CPHA=0
//  i_cs_n     in   1  chip select, active low, async
//  i_mosi     in   1  serial data in, MSB first
//  o_miso     out  1  serial data out, MSB first
//  o_miso_oe  out  1  MISO output enable (drive pad only when 1)
//  o_mode     out  2  current mode register bits [7:6]
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, o_miso=0, o_miso_oe=0, mode=2'b01
//   (sequential), shift count 0. Memory contents are NOT cleared by reset.
//  Input sync: 2-flop synchronisers on sck/cs_n/mosi; rise/fall = compare with 3rd flop.
//   Requires SCK high and low each >= 3 i_clk periods; mosi sampled from synced copy on rise.
//  Bit timing: shift-in on synced SCK rise; next MISO bit registered on synced SCK fall.
//   o_miso changes 3 i_clk after raw SCK falls (2 sync + 1 reg). Bit counter 0..7 per byte.
//  FSM: IDLE -(cs_n fall)-> CMD. CMD after 8 bits: 0x03->ADDR(rd), 0x02->ADDR(wr),
//   0x05->MODE_RD, 0x01->MODE_WR, other->IGNORE. ADDR after 8*ADDR_BYTES bits: RDATA or WDATA.
//   RDATA: array read combinational at addr at end of last addr bit; bit7 driven on next SCK
//   fall, o_miso_oe=1 from that fall until cs_n rise. After each 8th bit addr advances, next byte
//   loaded. WDATA: byte written on the rise completing bit 0, then addr advances.
//   MODE_RD: shifts out {mode,6'b0}, repeats each byte. MODE_WR: first complete byte sets
//   mode=byte[7:6] (11 treated as 01); further bytes ignored. IGNORE: no output, no writes.
//  Any state -(synced cs_n high)-> IDLE same cycle; o_miso_oe=0, o_miso=0 next cycle.
//  Address advance: mode 00 byte: after first data byte go IGNORE (no further R/W).
//   mode 10 page: addr = {addr[aw-1:p], addr[p-1:0]+1}, p=log2(PAGE_SIZE) (wraps in page).
//   mode 01 sequential: addr+1 modulo depth (depth-1 -> 0).
//  Boundaries: cs_n rise mid-byte discards partial write byte, no array change; cs_n rise and
//   SCK edge in same i_clk -> cs_n wins, edge ignored; SCK edges while cs_n high ignored;
//   reset mid-transaction aborts, no partial write, mode back to 01.
//  Array: single write port on i_clk (posedge), byte wide, one write per completed byte.
// TESTING
//  1 Reset, RDMR (0x05) -> MISO byte 0x40, o_mode=01, oe=0 before 1st SCK fall after opcode.
//  2 WRITE 0x02 addr 0x0010 data AA 55 C3, then READ 0x03 addr 0x0010 x3 -> AA 55 C3.
//  3 Sequential write at addr depth-1 (0xFFFF) data 11 22 -> mem[FFFF]=11, mem[0000]=22.
//  4 WRMR 0x80 (page), WRITE at 0x001F data 01 02 -> mem[1F]=01, mem[00]=02, mem[20] unchanged.
//  5 WRMR 0x00 (byte), WRITE 0x0100 data 77 88 -> mem[100]=77, mem[101] unchanged; read 2 bytes
//    -> first 77, oe=0 during second byte.
//  6 WRITE 0x0200 then cs_n high after 5 data bits -> mem[200] unchanged; opcode 0x9F ignored;
//    i_rst_n low mid-READ -> oe=0 immediately, next RDMR returns 0x40.

Source files
------------

// File: rtl/servant_spi_sram_slave.sv
// Serial SRAM (23LC-style) SPI mode-0 slave with READ/WRITE/RDMR/WRMR, all on i_clk.
// SCK/CS_N/MOSI are synchronised and edge-detected; no logic runs in the SCK domain.
module servant_spi_sram_slave #(
    parameter int depth      = 65536,
    parameter int aw         = $clog2(depth),
    parameter int ADDR_BYTES = 2,
    parameter int PAGE_SIZE  = 32,
    parameter     memfile    = ""
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sck,
    input  logic       i_cs_n,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_miso_oe,
    output logic [1:0] o_mode
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_RDATA, ST_WDATA, ST_MODE_RD, ST_MODE_WR, ST_IGNORE
    } state_t;

    localparam logic [1:0]    MODE_BYTE  = 2'b00;
    localparam logic [1:0]    MODE_SEQ   = 2'b01;
    localparam logic [1:0]    MODE_PAGE  = 2'b10;
    localparam logic [aw-1:0] PAGE_MASK  = aw'(PAGE_SIZE - 1);
    localparam logic [1:0]    LAST_ABYTE = 2'(ADDR_BYTES - 1);

    logic [7:0] mem [depth];

    state_t        state, state_nxt;
    logic [2:0]    sck_s, cs_s;
    logic [1:0]    mosi_s;
    logic [2:0]    bit_cnt;
    logic [1:0]    addr_byte_cnt;
    logic [7:0]    rx_sr, tx_sr;
    logic [aw-1:0] addr;
    logic          is_rd;
    logic [1:0]    mode;

    logic          cs_high, cs_fall, sck_rise, sck_fall, byte_done, read_state;
    logic [7:0]    new_byte, rd_byte;
    logic [aw+7:0] addr_cat;
    logic [aw-1:0] addr_shift, addr_inc, addr_adv, rd_addr;

    // 2-flop synchronisers plus a third flop for edge detection; cs_n idles high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_s  <= 3'b000;
            cs_s   <= 3'b111;
            mosi_s <= 2'b00;
        end else begin
            sck_s  <= {sck_s[1:0], i_sck};
            cs_s   <= {cs_s[1:0], i_cs_n};
            mosi_s <= {mosi_s[0], i_mosi};
        end
    end

    // A deasserted chip select masks SCK edges in the same cycle.
    assign cs_high    = cs_s[1];
    assign cs_fall    = ~cs_s[1] & cs_s[2];
    assign sck_rise   = ~cs_high & sck_s[1] & ~sck_s[2];
    assign sck_fall   = ~cs_high & ~sck_s[1] & sck_s[2];
    assign byte_done  = sck_rise && (bit_cnt == 3'd7);
    assign new_byte   = {rx_sr[6:0], mosi_s[1]};
    assign read_state = (state == ST_RDATA) || (state == ST_MODE_RD);

    assign addr_cat   = {addr, new_byte};
    assign addr_shift = addr_cat[aw-1:0];
    assign addr_inc   = addr + aw'(1);

    always_comb begin
        addr_adv = addr_inc;
        if (mode == MODE_PAGE)
            addr_adv = (addr & ~PAGE_MASK) | (addr_inc & PAGE_MASK);
        rd_addr = (state == ST_ADDR) ? addr_shift : addr_adv;
    end

    assign rd_byte = mem[rd_addr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_high) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
                ST_CMD: if (byte_done) begin
                    case (new_byte)
                        8'h03, 8'h02: state_nxt = ST_ADDR;
                        8'h05:        state_nxt = ST_MODE_RD;
                        8'h01:        state_nxt = ST_MODE_WR;
                        default:      state_nxt = ST_IGNORE;
                    endcase
                end
                ST_ADDR: if (byte_done && addr_byte_cnt == LAST_ABYTE)
                    state_nxt = is_rd ? ST_RDATA : ST_WDATA;
                ST_RDATA, ST_WDATA: if (byte_done && mode == MODE_BYTE)
                    state_nxt = ST_IGNORE;
                ST_MODE_WR: if (byte_done) state_nxt = ST_IGNORE;
                default: ;
            endcase
        end
    end

    // NOTE: all sequential state uses <= so every flop samples pre-edge values regardless of order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt       <= 3'd0;
            addr_byte_cnt <= 2'd0;
            rx_sr         <= 8'h00;
            tx_sr         <= 8'h00;
            addr          <= '0;
            is_rd         <= 1'b0;
            mode          <= MODE_SEQ;
            o_miso        <= 1'b0;
            o_miso_oe     <= 1'b0;
        end else if (cs_high) begin
            bit_cnt       <= 3'd0;
            addr_byte_cnt <= 2'd0;
            o_miso        <= 1'b0;
            o_miso_oe     <= 1'b0;
        end else begin
            if (sck_rise) begin
                rx_sr   <= new_byte;
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_done) begin
                    case (state)
                        ST_CMD: begin
                            is_rd <= (new_byte == 8'h03);
                            tx_sr <= {mode, 6'b0};
                        end
                        ST_ADDR: begin
                            addr          <= addr_shift;
                            addr_byte_cnt <= addr_byte_cnt + 2'd1;
                            tx_sr         <= rd_byte;
                        end
                        ST_RDATA: begin
                            addr  <= addr_adv;
                            tx_sr <= rd_byte;
                        end
                        ST_WDATA:   addr  <= addr_adv;
                        ST_MODE_RD: tx_sr <= {mode, 6'b0};
                        ST_MODE_WR: mode  <= (new_byte[7:6] == 2'b11) ? MODE_SEQ : new_byte[7:6];
                        default: ;
                    endcase
                end
            end else if (sck_fall && read_state) begin
                o_miso    <= tx_sr[7];
                o_miso_oe <= 1'b1;
                tx_sr     <= {tx_sr[6:0], 1'b0};
            end
            if (!read_state) begin
                o_miso    <= 1'b0;
                o_miso_oe <= 1'b0;
            end
        end
    end

    // NOTE: the storage array has no reset; contents survive i_rst_n and state reset blocks writes.
    always_ff @(posedge i_clk) begin
        if (byte_done && state == ST_WDATA)
            mem[addr] <= new_byte;
    end

    assign o_mode = mode;

endmodule

// File: tb/tb_servant_spi_sram_slave.sv
// Directed bench for servant_spi_sram_slave: drives SPI mode-0 transactions and checks
// read-back data, MISO enable, mode register, wrap modes and abort/reset boundaries.
module tb_servant_spi_sram_slave;

    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sck, cs_n, mosi;
    logic       miso, miso_oe;
    logic [1:0] mode;

    int tests = 0;
    int fails = 0;

    logic [7:0] rx, oe;

    servant_spi_sram_slave dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_sck     (sck),
        .i_cs_n    (cs_n),
        .i_mosi    (mosi),
        .o_miso    (miso),
        .o_miso_oe (miso_oe),
        .o_mode    (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift n bits MSB first; MISO and its enable are sampled at each SCK rise.
    task automatic spi_bits(input logic [7:0] tx, input int n,
                            output logic [7:0] rx_o, output logic [7:0] oe_o);
        rx_o = 8'h00;
        oe_o = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = tx[i];
            clks(HALF);
            sck = 1'b1;
            rx_o[i] = miso;
            oe_o[i] = miso_oe;
            clks(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx);
        spi_bits(tx, 8, rx, oe);
    endtask

    task automatic cs_begin();
        clks(HALF);
        cs_n = 1'b0;
        clks(HALF);
    endtask

    task automatic cs_end();
        clks(HALF);
        cs_n = 1'b1;
        clks(HALF);
    endtask

    task automatic write1(input logic [15:0] a, input logic [7:0] d);
        cs_begin();
        xfer(8'h02); xfer(a[15:8]); xfer(a[7:0]); xfer(d);
        cs_end();
    endtask

    task automatic read_cmd(input logic [15:0] a);
        cs_begin();
        xfer(8'h03); xfer(a[15:8]); xfer(a[7:0]);
    endtask

    task automatic wrmr(input logic [7:0] m);
        cs_begin();
        xfer(8'h01); xfer(m);
        cs_end();
    endtask

    initial begin
        sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; rst_n = 1'b0;
        clks(5);
        check("reset_miso", 16'(miso), 16'h0);
        check("reset_oe", 16'(miso_oe), 16'h0);
        check("reset_mode", 16'(mode), 16'h1);
        rst_n = 1'b1;
        clks(5);

        // RDMR after reset
        cs_begin();
        xfer(8'h05);
        check("rdmr_oe_before_fall", 16'(miso_oe), 16'h0);
        xfer(8'h00);
        check("rdmr_byte", 16'(rx), 16'h40);
        check("rdmr_oe_on", 16'(oe), 16'hFF);
        xfer(8'h00);
        check("rdmr_repeat", 16'(rx), 16'h40);
        cs_end();
        check("rdmr_oe_off", 16'(miso_oe), 16'h0);
        check("mode_seq", 16'(mode), 16'h1);

        // Sequential burst write / read
        cs_begin();
        xfer(8'h02); xfer(8'h00); xfer(8'h10);
        xfer(8'hAA); xfer(8'h55); xfer(8'hC3);
        cs_end();
        read_cmd(16'h0010);
        xfer(8'h00); check("rd_0010", 16'(rx), 16'hAA);
        xfer(8'h00); check("rd_0011", 16'(rx), 16'h55);
        xfer(8'h00); check("rd_0012", 16'(rx), 16'hC3);
        cs_end();

        // Wrap at top of array
        cs_begin();
        xfer(8'h02); xfer(8'hFF); xfer(8'hFF); xfer(8'h11); xfer(8'h22);
        cs_end();
        read_cmd(16'hFFFF);
        xfer(8'h00); check("rd_ffff", 16'(rx), 16'h11);
        xfer(8'h00); check("rd_wrap_0000", 16'(rx), 16'h22);
        cs_end();

        // Page mode wrap inside a 32-byte page
        write1(16'h0020, 8'h5A);
        write1(16'h0101, 8'h3C);
        wrmr(8'h80);
        check("mode_page", 16'(mode), 16'h2);
        cs_begin();
        xfer(8'h02); xfer(8'h00); xfer(8'h1F); xfer(8'h01); xfer(8'h02);
        cs_end();
        read_cmd(16'h001F);
        xfer(8'h00); check("pg_rd_001f", 16'(rx), 16'h01);
        xfer(8'h00); check("pg_rd_0000", 16'(rx), 16'h02);
        cs_end();
        read_cmd(16'h0020);
        xfer(8'h00); check("pg_0020_kept", 16'(rx), 16'h5A);
        cs_end();

        // Byte mode: one data byte per transaction
        wrmr(8'h00);
        check("mode_byte", 16'(mode), 16'h0);
        cs_begin();
        xfer(8'h02); xfer(8'h01); xfer(8'h00); xfer(8'h77); xfer(8'h88);
        cs_end();
        read_cmd(16'h0100);
        xfer(8'h00);
        check("byte_rd_0100", 16'(rx), 16'h77);
        check("byte_oe_first", 16'(oe), 16'hFF);
        xfer(8'h00);
        check("byte_oe_second", 16'(oe), 16'h00);
        check("byte_rx_second", 16'(rx), 16'h00);
        cs_end();
        wrmr(8'hC0);
        check("mode_11_as_seq", 16'(mode), 16'h1);
        read_cmd(16'h0101);
        xfer(8'h00); check("byte_0101_kept", 16'(rx), 16'h3C);
        cs_end();

        // Partial write byte aborted by chip select
        write1(16'h0200, 8'hE1);
        cs_begin();
        xfer(8'h02); xfer(8'h02); xfer(8'h00);
        spi_bits(8'h12, 5, rx, oe);
        cs_end();
        read_cmd(16'h0200);
        xfer(8'h00); check("partial_discard", 16'(rx), 16'hE1);
        cs_end();

        // Unknown opcode: no output, no writes
        cs_begin();
        xfer(8'h9F); xfer(8'h02); xfer(8'h02);
        check("ignore_oe", 16'(oe), 16'h00);
        check("ignore_rx", 16'(rx), 16'h00);
        cs_end();
        read_cmd(16'h0200);
        xfer(8'h00); check("ignore_no_write", 16'(rx), 16'hE1);
        cs_end();

        // Reset in the middle of a read
        wrmr(8'h80);
        check("mode_page_again", 16'(mode), 16'h2);
        read_cmd(16'h0200);
        spi_bits(8'h00, 3, rx, oe);
        check("mid_read_oe_on", 16'(oe), 16'hE0);
        clks(2);
        rst_n = 1'b0;
        #1;
        check("rst_oe_off", 16'(miso_oe), 16'h0);
        check("rst_mode", 16'(mode), 16'h1);
        clks(3);
        cs_n = 1'b1;
        clks(3);
        rst_n = 1'b1;
        clks(5);
        cs_begin();
        xfer(8'h05); xfer(8'h00);
        check("post_rst_rdmr", 16'(rx), 16'h40);
        cs_end();
        read_cmd(16'h0200);
        xfer(8'h00); check("mem_survives_rst", 16'(rx), 16'hE1);
        cs_end();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
